// File: rtl/ram16x8_arbiter.sv
// Round-robin arbiter sharing one 16x8 single-port RAM between requesters A and B.
// Define RAM16X8_ARB_CLEAR_EN to build the post-reset sweep that writes INIT_VAL everywhere.
module ram16x8_arbiter #(
   parameter int            AW       = 4,
   parameter int            DW       = 8,
   parameter logic [DW-1:0] INIT_VAL = 8'h00
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          busy
);

`ifdef RAM16X8_ARB_CLEAR_EN
   typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
`endif

   localparam logic [AW-1:0] ADDR_MAX = '1;

   state_t        state_q;
   logic          prio_q;
   logic          win_q;
   logic          busy_q;
   logic          ram_we_q;
   logic [AW-1:0] ram_addr_q;
   logic [DW-1:0] ram_din_q;
   logic          a_ack_q;
   logic          b_ack_q;
   logic [DW-1:0] a_rdata_q;
   logic [DW-1:0] b_rdata_q;
   logic          grant_b_d;

   // B wins when it is the only requester, or when both ask and B holds priority.
   assign grant_b_d = b_req & (~a_req | prio_q);

`ifdef RAM16X8_ARB_CLEAR_EN
   logic [AW-1:0] clr_cnt_q;
   logic [AW-1:0] clr_cnt_d;

   assign clr_cnt_d = (clr_cnt_q == ADDR_MAX) ? clr_cnt_q : clr_cnt_q + 1'b1;
`endif

   // The RAM command registers double as the latched request, so ACCESS drives the RAM
   // straight from the values captured at grant time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef RAM16X8_ARB_CLEAR_EN
         state_q   <= CLEAR;
         busy_q    <= 1'b1;
         clr_cnt_q <= '0;
`else
         state_q   <= IDLE;
         busy_q    <= 1'b0;
`endif
         prio_q     <= 1'b0;
         win_q      <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= INIT_VAL;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         case (state_q)
`ifdef RAM16X8_ARB_CLEAR_EN
            // The sweep write for an address is loaded one edge ahead; leave once the
            // last address has actually been written.
            CLEAR: begin
               if (ram_we_q && (ram_addr_q == ADDR_MAX)) begin
                  ram_we_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  ram_we_q   <= 1'b1;
                  ram_addr_q <= clr_cnt_q;
                  ram_din_q  <= INIT_VAL;
                  clr_cnt_q  <= clr_cnt_d;
               end
            end
`endif
            IDLE: begin
               if (a_req || b_req) begin
                  win_q      <= grant_b_d;
                  ram_we_q   <= grant_b_d ? b_we    : a_we;
                  ram_addr_q <= grant_b_d ? b_addr  : a_addr;
                  ram_din_q  <= grant_b_d ? b_wdata : a_wdata;
                  busy_q     <= 1'b1;
                  state_q    <= ACCESS;
               end
            end
            ACCESS: begin
               if (!ram_we_q) begin
                  if (win_q) b_rdata_q <= ram_dout;
                  else       a_rdata_q <= ram_dout;
               end
               a_ack_q  <= ~win_q;
               b_ack_q  <= win_q;
               ram_we_q <= 1'b0;
               state_q  <= DONE;
            end
            DONE: begin
               a_ack_q <= 1'b0;
               b_ack_q <= 1'b0;
               prio_q  <= ~win_q;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               ram_we_q <= 1'b0;
               a_ack_q  <= 1'b0;
               b_ack_q  <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign a_ack    = a_ack_q;
   assign b_ack    = b_ack_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_ram16x8_arbiter.sv
// Self-checking bench for ram16x8_arbiter with a behavioural 16x8 RAM (sync write, async read).
// Honours RAM16X8_ARB_CLEAR_EN to pick the expected post-reset behaviour.
module tb_ram16x8_arbiter;

`ifdef RAM16X8_ARB_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_req, a_we, b_req, b_we;
   logic [3:0] a_addr, b_addr;
   logic [7:0] a_wdata, b_wdata;
   logic       a_ack, b_ack, ram_we, busy;
   logic [7:0] a_rdata, b_rdata, ram_din, ram_dout;
   logic [3:0] ram_addr;

   logic [7:0] mem [16] = '{default: 8'h55};

   int passCount  = 0;
   int checkCount = 0;
   logic [7:0] lastA, lastB;

   typedef struct {
      logic       side;
      logic       we;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } vec_t;

   vec_t vecs [11];

   ram16x8_arbiter #(.AW(4), .DW(8), .INIT_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural RAM the arbiter drives.
   always @(posedge clk) begin
      if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
   end
   assign ram_dout = mem[ram_addr];

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Invariants sampled mid-cycle: acks are exclusive, and RAM writes only happen while busy
   // and never in the ack (DONE) cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checkOutput("ack_exclusive", {7'b0, a_ack & b_ack}, 8'h00);
         checkOutput("we_outside_access", {7'b0, ram_we & (~busy | a_ack | b_ack)}, 8'h00);
      end
   end

   task automatic waitIdle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput(name, {7'b0, busy}, 8'h00);
   endtask

   task automatic applyReset();
      a_req = 1'b0; b_req = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      lastA = 8'h00; lastB = 8'h00;
   endtask

   // One complete access from IDLE: ack must arrive 2 cycles after the sampling cycle.
   task automatic applyStimulus(input string name, input logic side, input logic we,
                                input logic [3:0] addr, input logic [7:0] wdata,
                                input logic [7:0] expRdata);
      int ackAt = 0;
      if (side) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
      else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if ((side ? b_ack : a_ack) === 1'b1) begin
            ackAt = k;
            break;
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      checkOutput({name, "_ack_latency"}, 8'(ackAt), 8'd2);
      if (!we) begin
         if (side) lastB = expRdata;
         else      lastA = expRdata;
      end
      checkOutput({name, "_a_rdata"}, a_rdata, lastA);
      checkOutput({name, "_b_rdata"}, b_rdata, lastB);
      @(posedge clk); #1;
   endtask

   initial begin
      int busyCycles;
      int nAck;
      int ackSide [4];
      int ackCyc [4];
      int aAckAt, bAckAt;

      vecs[0]  = '{1'b0, 1'b1, 4'd3,  8'hA5, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, 4'd3,  8'h00, 8'hA5};
      vecs[2]  = '{1'b0, 1'b1, 4'd15, 8'hFF, 8'h00};
      vecs[3]  = '{1'b0, 1'b0, 4'd15, 8'h00, 8'hFF};
      vecs[4]  = '{1'b1, 1'b1, 4'd0,  8'h12, 8'h00};
      vecs[5]  = '{1'b0, 1'b0, 4'd0,  8'h00, 8'h12};
      vecs[6]  = '{1'b1, 1'b1, 4'd7,  8'h42, 8'h00};
      vecs[7]  = '{1'b1, 1'b0, 4'd7,  8'h00, 8'h42};
      vecs[8]  = '{1'b0, 1'b0, 4'd3,  8'h00, 8'hA5};
      vecs[9]  = '{1'b1, 1'b1, 4'd3,  8'h5A, 8'h00};
      vecs[10] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'h5A};

      rst_n = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      lastA = 8'h00; lastB = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy",    {7'b0, busy},   {7'b0, CLR});
      checkOutput("reset_ram_we",  {7'b0, ram_we}, 8'h00);
      checkOutput("reset_a_ack",   {7'b0, a_ack},  8'h00);
      checkOutput("reset_b_ack",   {7'b0, b_ack},  8'h00);
      checkOutput("reset_a_rdata", a_rdata, 8'h00);
      checkOutput("reset_b_rdata", b_rdata, 8'h00);

      // Busy is counted once per clock edge after release.
      @(negedge clk); rst_n = 1'b1;
      busyCycles = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (busy === 1'b1) busyCycles++;
         else break;
      end
      checkOutput("clear_busy_cycles", 8'(busyCycles), CLR ? 8'd16 : 8'd0);

      if (CLR) begin
         for (int i = 0; i < 16; i++)
            applyStimulus($sformatf("clear_rd%0d", i), 1'b0, 1'b0, 4'(i), 8'h00, 8'h00);
      end

      for (int i = 0; i < 11; i++)
         applyStimulus($sformatf("vec%0d", i), vecs[i].side, vecs[i].we, vecs[i].addr,
                       vecs[i].wdata, vecs[i].rdata);

      // Both requesters held high from reset: grants must alternate A,B,A,B every 3 cycles.
      applyReset();
      waitIdle("fair_idle");
      a_we = 1'b0; a_addr = 4'd1; b_we = 1'b0; b_addr = 4'd2;
      a_req = 1'b1; b_req = 1'b1;
      nAck = 0;
      for (int c = 1; c <= 30 && nAck < 4; c++) begin
         @(posedge clk); #1;
         if (a_ack === 1'b1 && nAck < 4) begin ackSide[nAck] = 0; ackCyc[nAck] = c; nAck++; end
         if (b_ack === 1'b1 && nAck < 4) begin ackSide[nAck] = 1; ackCyc[nAck] = c; nAck++; end
      end
      a_req = 1'b0; b_req = 1'b0;
      checkOutput("fair_ack_count", 8'(nAck), 8'd4);
      for (int i = 0; i < nAck; i++) begin
         checkOutput($sformatf("fair_order%0d", i), 8'(ackSide[i]), 8'(i % 2));
         if (i > 0) checkOutput($sformatf("fair_gap%0d", i), 8'(ackCyc[i] - ackCyc[i-1]), 8'd3);
      end
      lastA = CLR ? 8'h00 : 8'h55;
      lastB = CLR ? 8'h00 : 8'h55;
      checkOutput("fair_a_rdata", a_rdata, lastA);
      checkOutput("fair_b_rdata", b_rdata, lastB);
      @(posedge clk); #1;

      // B arrives while A is in ACCESS: B served in the following IDLE, acked 5 cycles after A's sample.
      waitIdle("late_b_idle");
      a_we = 1'b1; a_addr = 4'd9; a_wdata = 8'h77; a_req = 1'b1;
      aAckAt = 0; bAckAt = 0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin b_we = 1'b0; b_addr = 4'd9; b_req = 1'b1; end
         if (a_ack === 1'b1) begin aAckAt = c; a_req = 1'b0; end
         if (b_ack === 1'b1) begin bAckAt = c; b_req = 1'b0; break; end
      end
      a_req = 1'b0; b_req = 1'b0;
      checkOutput("late_b_a_ack_cycle", 8'(aAckAt), 8'd2);
      checkOutput("late_b_b_ack_cycle", 8'(bAckAt), 8'd5);
      checkOutput("late_b_rdata", b_rdata, 8'h77);
      lastB = 8'h77;
      @(posedge clk); #1;

      // Reset during a write ACCESS aborts the write immediately.
      waitIdle("abort_idle");
      a_we = 1'b1; a_addr = 4'd7; a_wdata = 8'h3C; a_req = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_we_in_access", {7'b0, ram_we}, 8'h01);
      checkOutput("abort_addr", {4'b0, ram_addr}, 8'h07);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_we_forced", {7'b0, ram_we}, 8'h00);
      checkOutput("abort_ack_forced", {7'b0, a_ack}, 8'h00);
      a_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      lastA = 8'h00; lastB = 8'h00;
      waitIdle("abort_restart_idle");
      applyStimulus("abort_readback", 1'b0, 1'b0, 4'd7, 8'h00, CLR ? 8'h00 : 8'h42);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
